// File: rtl/router_pkg.sv
// Shared definitions for the bus router: ID field width, bus FSM states and the
// destination-ID extraction helper.
package router_pkg;

    localparam int ID_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        POP     = 2'd1,
        DELIVER = 2'd2
    } state_t;

    // The destination ID occupies the top ID_W bits of a packet of width pck_w (pck_w <= 64).
    function automatic logic [ID_W-1:0] dest_id(input logic [63:0] pkt, input int pck_w);
        return pkt[pck_w-1 -: ID_W];
    endfunction

endpackage

// File: rtl/router_out_fifo.sv
// Per-terminal output FIFO. A write is accepted on a full FIFO when a pop happens in
// the same cycle; head reads as zero while empty.
module router_out_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
        if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/router_bus_generator.sv
// Shared-bus router: round-robin arbiter plus IDLE/POP/DELIVER FSM moving one packet at a
// time from a terminal source FIFO into one output FIFO, or all others on broadcast.
module router_bus_generator
    import router_pkg::*;
#(
    parameter int              num_ntrfs  = 4,
    parameter int              pck_sz     = 16,
    parameter logic [ID_W-1:0] broadcast  = 8'hFF,
    parameter int              fifo_depth = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [num_ntrfs-1:0][pck_sz-1:0]    data_out_i_in,
    input  logic [num_ntrfs-1:0]                push,
    output logic [num_ntrfs-1:0]                popin,
    input  logic [num_ntrfs-1:0]                pop,
    output logic [num_ntrfs-1:0]                pndng,
    output logic [num_ntrfs-1:0][pck_sz-1:0]    data_out
);

    localparam int GW = (num_ntrfs > 1) ? $clog2(num_ntrfs) : 1;

    state_t              state_q, state_d;
    logic [GW-1:0]       grant_q, grant_d;
    logic [GW-1:0]       rr_q, rr_d;
    logic [pck_sz-1:0]   pkt_q, pkt_d;

    logic [num_ntrfs-1:0] full, empty, space, target, wr_en;
    logic [ID_W-1:0]      id;
    logic                 deliver_ok;

    // Target decode: broadcast excludes the source, a valid ID may address the source itself.
    always_comb begin
        target = '0;
        id     = dest_id(64'(pkt_q), pck_sz);
        if (id == broadcast) begin
            target          = '1;
            target[grant_q] = 1'b0;
        end else if (int'(id) < num_ntrfs) begin
            target[id[GW-1:0]] = 1'b1;
        end
    end

    assign space      = ~full | pop;
    assign deliver_ok = &(space | ~target);
    assign wr_en      = (state_q == DELIVER && deliver_ok) ? target : '0;
    assign pndng      = ~empty;

    always_comb begin
        logic          found;
        logic [GW-1:0] idx;
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        pkt_d   = pkt_q;
        popin   = '0;
        found   = 1'b0;
        idx     = '0;
        case (state_q)
            IDLE: begin
                for (int k = 0; k < num_ntrfs; k++) begin
                    idx = GW'((int'(rr_q) + k) % num_ntrfs);
                    if (!found && push[idx]) begin
                        found   = 1'b1;
                        grant_d = idx;
                    end
                end
                if (found) state_d = POP;
            end
            POP: begin
                popin[grant_q] = 1'b1;
                pkt_d          = data_out_i_in[grant_q];
                state_d        = DELIVER;
            end
            DELIVER: begin
                // All-or-nothing: a broadcast waits until every target has room.
                if (deliver_ok) begin
                    rr_d    = (grant_q == GW'(num_ntrfs - 1)) ? '0 : grant_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
        end
    end

    always_ff @(posedge clk) begin
        pkt_q <= pkt_d;
    end

    for (genvar i = 0; i < num_ntrfs; i++) begin : g_out
        router_out_fifo #(
            .DEPTH (fifo_depth),
            .WIDTH (pck_sz)
        ) u_fifo (
            .clk_i   (clk),
            .rst_i   (reset),
            .push_i  (wr_en[i]),
            .pop_i   (pop[i]),
            .din_i   (pkt_q),
            .full_o  (full[i]),
            .empty_o (empty[i]),
            .head_o  (data_out[i])
        );
    end

endmodule

// File: tb/tb_router_bus_generator.sv
// Bench for router_bus_generator: directed scenarios plus random traffic, checked against a
// queue-based model of source FIFOs, round-robin order and per-terminal delivered packets.
module tb_router_bus_generator;

    localparam int N = 4;
    localparam int W = 16;

    logic                clk = 1'b0;
    logic                reset;
    logic [N-1:0][W-1:0] data_out_i_in;
    logic [N-1:0]        push;
    logic [N-1:0]        popin;
    logic [N-1:0]        pop;
    logic [N-1:0]        pndng;
    logic [N-1:0][W-1:0] data_out;

    always #5 clk = ~clk;

    router_bus_generator #(
        .num_ntrfs  (N),
        .pck_sz     (W),
        .broadcast  (8'hFF),
        .fifo_depth (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .data_out_i_in (data_out_i_in),
        .push          (push),
        .popin         (popin),
        .pop           (pop),
        .pndng         (pndng),
        .data_out      (data_out)
    );

    logic [W-1:0] srcq [N][$];
    logic [W-1:0] expq [N][$];
    int           grant_log [$];
    int           grant_cyc [$];
    int           checks = 0;
    int           failures = 0;
    int           cyc = 0;
    int           model_rr = 0;
    int           pend_pop = -1;
    int           last_pop_cyc = -100;
    int           last_grant = -1;
    int           pop_pct = 100;
    logic [N-1:0] prev_push = '0;
    logic [N-1:0] pop_en = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Which terminals should receive a packet sent by terminal src.
    function automatic logic [N-1:0] exp_targets(input logic [W-1:0] pkt, input int src);
        logic [7:0]   id;
        logic [N-1:0] m;
        id = pkt[W-1:W-8];
        m  = '0;
        for (int t = 0; t < N; t++)
            m[t] = (id == 8'hFF) ? (t != src) : (int'(id) == t);
        return m;
    endfunction

    function automatic bit model_busy();
        bit b;
        b = (pend_pop >= 0);
        for (int i = 0; i < N; i++)
            if (srcq[i].size() > 0 || expq[i].size() > 0) b = 1'b1;
        return b;
    endfunction

    task automatic enq(input int t, input logic [W-1:0] d);
        srcq[t].push_back(d);
    endtask

    // One clock: observe outputs at the falling edge, update the model, drive next inputs.
    task automatic tick();
        int           g;
        int           obs_g;
        logic [N-1:0] m;
        @(negedge clk);
        cyc++;
        if (pend_pop >= 0) begin
            if (srcq[pend_pop].size() > 0) void'(srcq[pend_pop].pop_front());
            pend_pop = -1;
        end
        if (popin != '0) begin
            g = -1;
            obs_g = -1;
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (model_rr + k) % N;
                if (g < 0 && prev_push[idx]) g = idx;
                if (obs_g < 0 && popin[k]) obs_g = k;
            end
            check("popin_onehot", 64'($countones(popin)), 64'd1);
            check("popin_grant", 64'(popin), (g < 0) ? 64'd0 : (64'd1 << g));
            check("popin_spacing", 64'(cyc - last_pop_cyc >= 3), 64'd1);
            last_pop_cyc = cyc;
            last_grant = obs_g;
            grant_log.push_back(obs_g);
            grant_cyc.push_back(cyc);
            if (g >= 0 && srcq[g].size() > 0) begin
                m = exp_targets(srcq[g][0], g);
                for (int t = 0; t < N; t++)
                    if (m[t]) expq[t].push_back(srcq[g][0]);
                pend_pop = g;
                model_rr = (g + 1) % N;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (pndng[i]) begin
                if (expq[i].size() == 0) check("pndng_spurious", 64'(pndng[i]), 64'd0);
                else                     check("data_head", 64'(data_out[i]), 64'(expq[i][0]));
            end else begin
                check("data_idle", 64'(data_out[i]), 64'd0);
            end
        end
        for (int i = 0; i < N; i++) begin
            pop[i] = pndng[i] && pop_en[i] && (int'($urandom_range(99)) < pop_pct);
            if (pop[i] && expq[i].size() > 0) void'(expq[i].pop_front());
        end
        for (int i = 0; i < N; i++) begin
            push[i] = (srcq[i].size() > 0);
            data_out_i_in[i] = push[i] ? srcq[i][0] : '0;
        end
        prev_push = push;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    initial begin
        int n0;
        int k;
        reset = 1'b1;
        push = '0;
        pop = '0;
        data_out_i_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_popin", 64'(popin), 64'd0);
        check("reset_pndng", 64'(pndng), 64'd0);
        check("reset_data", 64'(data_out), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Single packet terminal 1 -> terminal 2
        pop_en = '0;
        enq(1, 16'h02AB);
        run(6);
        check("single_pulses", 64'(grant_log.size()), 64'd1);
        check("single_grant", 64'(last_grant), 64'd1);
        check("single_pndng", 64'(pndng), 64'b0100);
        check("single_data", 64'(data_out[2]), 64'h02AB);
        pop_en = '1;
        run(3);
        check("single_drained", 64'(pndng), 64'd0);

        // Broadcast from terminal 0
        pop_en = '0;
        enq(0, 16'hFF55);
        run(6);
        check("bcast_pndng", 64'(pndng), 64'b1110);
        for (int i = 1; i < N; i++) check("bcast_data", 64'(data_out[i]), 64'hFF55);
        pop_en = '1;
        run(3);

        // Invalid destination is dropped, the next packet is still served
        pop_en = '0;
        n0 = grant_log.size();
        enq(0, 16'h0701);
        enq(1, 16'h0312);
        run(10);
        check("invalid_pulses", 64'(grant_log.size()), 64'(n0 + 2));
        check("invalid_pndng", 64'(pndng), 64'b1000);
        check("invalid_data", 64'(data_out[3]), 64'h0312);
        pop_en = '1;
        run(3);

        // Round robin with every terminal pushing continuously
        n0 = grant_log.size();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < 3; j++) enq(i, {8'((i + 1) % N), 8'(j)});
        run(45);
        check("rr_pulses", 64'(grant_log.size()), 64'(n0 + 12));
        for (int j = n0 + 1; j < n0 + 12 && j < grant_log.size(); j++) begin
            check("rr_order", 64'(grant_log[j]), 64'((grant_log[j-1] + 1) % N));
            check("rr_gap", 64'(grant_cyc[j] - grant_cyc[j-1]), 64'd3);
        end

        // Output FIFO 3 fills, the bus stalls, one pop lets the 17th packet in
        pop_en = 4'b0111;
        n0 = grant_log.size();
        for (int j = 0; j < 17; j++) enq(0, {8'h03, 8'(j)});
        run(66);
        check("full_pulses", 64'(grant_log.size()), 64'(n0 + 17));
        check("full_pndng3", 64'(pndng[3]), 64'd1);
        check("full_head", 64'(data_out[3]), 64'h0300);
        enq(1, 16'h0299);
        run(10);
        check("stall_pulses", 64'(grant_log.size()), 64'(n0 + 17));
        pop_en = 4'b1000;
        run(1);
        pop_en = 4'b0111;
        run(8);
        check("unstall_pulses", 64'(grant_log.size()), 64'(n0 + 18));
        check("unstall_head", 64'(data_out[3]), 64'h0301);
        pop_en = '1;
        run(60);
        check("full_drained", 64'(expq[3].size()), 64'd0);

        // Reset while a packet sits in DELIVER
        pop_en = '0;
        enq(2, 16'h0233);
        run(6);
        check("pre_reset_pndng", 64'(pndng), 64'b0100);
        n0 = grant_log.size();
        enq(0, 16'h0155);
        k = 0;
        while (grant_log.size() == n0 && k < 20) begin
            tick();
            k++;
        end
        check("pre_reset_popin_seen", 64'(grant_log.size()), 64'(n0 + 1));
        tick();
        reset = 1'b1;
        #1;
        check("midreset_pndng", 64'(pndng), 64'd0);
        check("midreset_popin", 64'(popin), 64'd0);
        check("midreset_data", 64'(data_out), 64'd0);
        for (int i = 0; i < N; i++) expq[i].delete();
        model_rr = 0;
        pend_pop = -1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        run(6);
        check("post_reset_no_replay", 64'(pndng), 64'd0);
        enq(2, 16'h0077);
        run(6);
        check("post_reset_pndng", 64'(pndng), 64'b0001);
        check("post_reset_data", 64'(data_out[0]), 64'h0077);
        pop_en = '1;
        run(3);

        // Random traffic with random output back-pressure
        pop_pct = 60;
        repeat (400) begin
            if ($urandom_range(99) < 35) begin
                int r;
                logic [7:0] id;
                r = int'($urandom_range(9));
                if (r < 6)      id = 8'(r % N);
                else if (r < 8) id = 8'hFF;
                else            id = 8'(4 + $urandom_range(250));
                enq(int'($urandom_range(N - 1)), {id, 8'($urandom)});
            end
            tick();
        end
        pop_pct = 100;
        k = 0;
        while (k < 3000 && model_busy()) begin
            tick();
            k++;
        end
        check("drain_done", 64'(model_busy()), 64'd0);
        run(2);
        check("final_pndng", 64'(pndng), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
